// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: valid/ready ratio load, changes applied only at period boundaries.
// Optional output period_cnt enabled by defining CLK_DIV_PERIOD_CNT_EN.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] active_div,
  output logic             div_clk,
  output logic             div_tick,
  output logic             busy
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W:0]   half_d;
  logic             xfer, legal, wrap;

  assign xfer  = cfg_valid && cfg_ready;
  assign legal = (cfg_div >= CNT_W'(2));
  assign wrap  = (cnt_q == act_q - CNT_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= CNT_W'(DEFAULT_DIV);
      pend_q  <= '0;
      err_q   <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    err_d   = xfer && !legal;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer && legal) act_d = cfg_div;
        if (run) state_d = RUN;
      end
      RUN: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        // Stopping wins over parking a ratio; an accepted ratio then loads directly since we are idle.
        if (wrap && !run) begin
          state_d = IDLE;
          if (xfer && legal) act_d = cfg_div;
        end else if (xfer && legal) begin
          state_d = PEND;
          pend_d  = cfg_div;
        end
      end
      PEND: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (wrap) begin
          act_d   = pend_q;
          state_d = run ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // div_clk/div_tick are registered from next-state values so they line up with cnt_q/state_q.
  always_comb begin
    cfg_ready = (state_q != PEND);
    busy      = (state_q != IDLE);
    half_d    = ({1'b0, act_d} + (CNT_W+1)'(1)) >> 1;
    clk_d     = (state_d != IDLE) && ({1'b0, cnt_d} < half_d);
    tick_d    = (state_d != IDLE) && (cnt_d == '0);
  end

  assign cfg_err    = err_q;
  assign active_div = act_q;
  assign div_clk    = clk_q;
  assign div_tick   = tick_q;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (state_q == IDLE && state_d == RUN) pcnt_d = '0;
    else if (state_q != IDLE && wrap)      pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

  assign period_cnt = pcnt_q;
`endif

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock-divider controller.
- Generates a divided clock-level signal and a period tick from the system clock.
- Accepts a new divide ratio through a valid/ready handshake, and sequences start, stop and ratio changes so they only take effect on period boundaries. This keeps `div_clk` free of runt pulses.
- Sits beside the fixed-ratio divider and serves blocks that need a divide ratio chosen at runtime.

Parameters:
- CNT_W, 16, width of the divide ratio and the internal period counter.
- DEFAULT_DIV, 10, active ratio after reset. Legal range is 2 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- run  input  1  level; 1 requests divided output, 0 requests a stop at the end of the current period.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  CNT_W  offered ratio N.
- cfg_ready  output  1  controller can accept a ratio.
- cfg_err  output  1  one-cycle pulse when an illegal ratio (N<2) is accepted-and-dropped.
- active_div  output  CNT_W  ratio currently in force.
- div_clk  output  1  registered divided clock level.
- div_tick  output  1  one-cycle pulse in the first cycle of each period.
- busy  output  1  1 in RUN or PEND.

Behaviour:
- Reset values (asynchronous, while n_rst=0):
  - state=IDLE, cnt=0, active_div=DEFAULT_DIV.
  - div_clk=0, div_tick=0, cfg_ready=1, cfg_err=0, busy=0.
- Handshake:
  - A transfer occurs in any cycle with cfg_valid=1 and cfg_ready=1.
  - cfg_ready = (state != PEND).
  - If cfg_div<2 at transfer: cfg_err=1 on the next cycle, and state and active_div are unchanged.
- Period definitions, with N = active_div and H = (N+1)>>1:
  - cnt counts 0..N-1, then wraps to 0.
  - div_clk=1 exactly in the cycles where cnt<H and state is RUN or PEND. It is 0 otherwise.
  - Result: high for ceil(N/2) cycles, low for floor(N/2) cycles.
  - div_tick=1 in the cycles where cnt=0 and state is RUN or PEND.
  - "Wrap" means the cycle with cnt=N-1.
- State machine:
  - IDLE:
    - A legal transfer loads active_div on the next edge.
    - run=1 moves to RUN; the first RUN cycle has cnt=0, div_clk=1 and div_tick=1.
    - If a transfer and run=1 occur in the same cycle, the new ratio is used for the first period.
  - RUN:
    - A legal transfer latches the ratio into a pending register and moves to PEND.
    - At wrap with run=0, move to IDLE; cnt returns to 0 and div_clk goes to 0.
    - At wrap with run=1, continue.
  - PEND:
    - At wrap, active_div takes the pending value and the next cycle starts a new period at cnt=0 with the new N.
    - That next cycle is RUN if run=1, otherwise IDLE.
- Deasserting run never truncates a period.
- A run pulse shorter than one period still produces at least one full period.
- A transfer in the same cycle as a RUN wrap goes to PEND and is applied at the following wrap. It does not affect the period that is just starting.
- cnt is CNT_W bits wide.
  - When N=2^CNT_W-1, cnt wraps correctly.
  - Comparisons are unsigned and nothing overflows.
- Reset mid-operation clears everything to reset values immediately. A pending ratio is discarded.

Optional Feature:
- Macro CLK_DIV_PERIOD_CNT_EN.
- When defined, adds output port period_cnt (16-bit):
  - Increments at every wrap in RUN or PEND and wraps at 0xFFFF→0.
  - Clears to 0 on each IDLE→RUN transition and on reset.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then run=1 with DEFAULT_DIV=10 → div_clk 5 cycles high then 5 low, repeating; div_tick every 10 cycles starting in the first RUN cycle; busy=1.
- In IDLE, write cfg_div=3, then run=1 → active_div=3 and div_clk pattern 1,1,0 repeating; write cfg_div=2 → pattern 1,0.
- N=10 running; at cnt=4 write cfg_div=4 → cfg_ready=0 until the wrap; the current period completes all 10 cycles; the next periods are 4 cycles (2 high, 2 low); active_div changes in the first 4-cycle period; a second cfg_valid held during PEND waits, then transfers.
- Write cfg_div=1, then cfg_div=0 → cfg_err pulses once per write; active_div and the div_clk period are unchanged.
- N=10; drop run at cnt=2 → the period finishes (8 more cycles), then state is IDLE with div_clk=0 and busy=0; a one-cycle run pulse from IDLE → exactly one full period.
- Assert n_rst=0 at cnt=3 in PEND → all outputs go to reset values asynchronously and active_div=10. With CLK_DIV_PERIOD_CNT_EN, period_cnt=0 after reset and equals 3 after three wraps.
